// File: rtl/symbol_serializer_pkg.sv
// Shared definitions for the FSK symbol serializer: FSM state encodings,
// default baud divider width and a constant log2 helper.
package symbol_serializer_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam int DEF_DIV_WIDTH = 16;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/symbol_serializer_baud_tick_gen.sv
// Baud period counter: counts 0..div and flags the terminal cycle.
// A start pulse restarts the period so each word begins on a fresh symbol.
module baud_tick_gen
  import symbol_serializer_pkg::*;
#(
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tick
);

  logic [DIV_WIDTH-1:0] r_cnt;

  assign tick = (r_cnt == div);

  // Clearing on the terminal count means the counter never passes div,
  // so an all-ones divider cannot wrap.
  always_ff @(posedge clk) begin
    if (rst || start || tick) r_cnt <= '0;
    else                      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/symbol_serializer.sv
// Word-to-symbol serializer for the FSK tone selector: one-word holding
// register, shift engine with programmable baud, gapless back-to-back words.
module symbol_serializer
  import symbol_serializer_pkg::*;
#(
  parameter int DATA_SIZE = 32,
  parameter int SYM_BITS  = 1,
  parameter int MSB_FIRST = 0,
  parameter int DIV_WIDTH = DEF_DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_SIZE-1:0] data,
  input  logic [DIV_WIDTH-1:0] baud_div,
  output logic                 ren,
  output logic [SYM_BITS-1:0]  sym_out,
  output logic                 sym_valid,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int NSYM = DATA_SIZE / SYM_BITS;
  localparam int SCW  = (clog2(NSYM) < 1) ? 1 : clog2(NSYM);
  localparam logic [SCW-1:0] LAST_SYM = SCW'(NSYM - 1);

  state_t                r_state, w_state_nxt;
  logic                  r_hold_full;
  logic [DATA_SIZE-1:0]  r_hold;
  logic [DATA_SIZE-1:0]  r_shift;
  logic [DATA_SIZE-1:0]  w_shift_adv;
  logic [SCW-1:0]        r_sym_cnt;
  logic [DIV_WIDTH-1:0]  r_div;
  logic                  r_first;
  logic [SYM_BITS-1:0]   w_cur_sym;
  logic                  w_tick, w_accept, w_last, w_start, w_advance;

  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign w_cur_sym   = r_shift[DATA_SIZE-1 -: SYM_BITS];
      assign w_shift_adv = r_shift << SYM_BITS;
    end else begin : g_lsb
      assign w_cur_sym   = r_shift[SYM_BITS-1:0];
      assign w_shift_adv = r_shift >> SYM_BITS;
    end
  endgenerate

  // ren is 0 whenever the holding register is full, so a reload and a new
  // accept can never land on the same edge.
  assign ren      = ~r_hold_full;
  assign w_accept = load & ~r_hold_full;
  assign w_last   = (r_sym_cnt == LAST_SYM);

  baud_tick_gen #(.DIV_WIDTH(DIV_WIDTH)) u_baud (
    .clk   (clk),
    .rst   (rst),
    .start (w_start),
    .div   (r_div),
    .tick  (w_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_advance   = 1'b0;
    sym_out     = '0;
    sym_valid   = 1'b0;
    busy        = 1'b0;
    frame_start = 1'b0;
    frame_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_start     = 1'b1;
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        sym_out     = w_cur_sym;
        sym_valid   = 1'b1;
        busy        = 1'b1;
        frame_start = r_first;
        if (w_tick) begin
          if (w_last) begin
            frame_done = 1'b1;
            if (r_hold_full) w_start     = 1'b1;
            else             w_state_nxt = ST_IDLE;
          end else begin
            w_advance = 1'b1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_full <= 1'b0;
      r_hold      <= '0;
      r_shift     <= '0;
      r_sym_cnt   <= '0;
      r_div       <= '0;
      r_first     <= 1'b0;
    end else begin
      r_first <= w_start;
      if (w_start) begin
        r_shift     <= r_hold;
        r_div       <= baud_div;
        r_sym_cnt   <= '0;
        r_hold_full <= 1'b0;
      end else if (w_advance) begin
        r_shift   <= w_shift_adv;
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end
      if (w_accept) begin
        r_hold      <= data;
        r_hold_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_symbol_serializer.sv
// Directed bench for symbol_serializer: a 1-bit LSB-first instance plus
// 2-bit LSB-first / MSB-first instances driven from a shared vector table.
module tb_symbol_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        a_load;
  logic [7:0]  a_data;
  logic [15:0] a_div;
  logic        a_ren, a_sym, a_sv, a_fs, a_fd, a_busy;

  logic        b_load;
  logic [7:0]  b_data;
  logic [3:0]  b_div;
  logic        b_ren, b_sv, b_fs, b_fd, b_busy;
  logic [1:0]  b_sym;
  logic        c_ren, c_sv, c_fs, c_fd, c_busy;
  logic [1:0]  c_sym;

  symbol_serializer #(.DATA_SIZE(8), .SYM_BITS(1), .MSB_FIRST(0), .DIV_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .load(a_load), .data(a_data), .baud_div(a_div),
    .ren(a_ren), .sym_out(a_sym), .sym_valid(a_sv), .frame_start(a_fs),
    .frame_done(a_fd), .busy(a_busy));

  symbol_serializer #(.DATA_SIZE(8), .SYM_BITS(2), .MSB_FIRST(0), .DIV_WIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .load(b_load), .data(b_data), .baud_div(b_div),
    .ren(b_ren), .sym_out(b_sym), .sym_valid(b_sv), .frame_start(b_fs),
    .frame_done(b_fd), .busy(b_busy));

  symbol_serializer #(.DATA_SIZE(8), .SYM_BITS(2), .MSB_FIRST(1), .DIV_WIDTH(4)) dut_c (
    .clk(clk), .rst(rst), .load(b_load), .data(b_data), .baud_div(b_div),
    .ren(c_ren), .sym_out(c_sym), .sym_valid(c_sv), .frame_start(c_fs),
    .frame_done(c_fd), .busy(c_busy));

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_a(input string nm, input logic sv, input logic sym,
                       input logic fs, input logic fd);
    chk({nm, "_sv"}, a_sv, sv);
    chk({nm, "_sym"}, a_sym, sym);
    chk({nm, "_fs"}, a_fs, fs);
    chk({nm, "_fd"}, a_fd, fd);
  endtask

  // exp_* are packed so that element [k] is the k-th symbol emitted
  typedef struct {
    logic [7:0]      data;
    logic [3:0]      div;
    logic [3:0][1:0] exp_lsb;
    logic [3:0][1:0] exp_msb;
  } vec_t;

  vec_t vecs[4];

  int t1[8]  = '{1, 0, 1, 0, 0, 1, 0, 1};
  int t4[16] = '{1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1};
  int t5[16] = '{0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    int w, n_valid, n_fd, fd_idx, bad;

    // B4: 0,1,3,2 / 2,3,1,0
    vecs[0].data = 8'hB4; vecs[0].div = 4'd0;
    vecs[0].exp_lsb = {2'd2, 2'd3, 2'd1, 2'd0};
    vecs[0].exp_msb = {2'd0, 2'd1, 2'd3, 2'd2};
    // 1B: 3,2,1,0 / 0,1,2,3
    vecs[1].data = 8'h1B; vecs[1].div = 4'd1;
    vecs[1].exp_lsb = {2'd0, 2'd1, 2'd2, 2'd3};
    vecs[1].exp_msb = {2'd3, 2'd2, 2'd1, 2'd0};
    // C6 at the all-ones divider: 2,1,0,3 / 3,0,1,2
    vecs[2].data = 8'hC6; vecs[2].div = 4'd15;
    vecs[2].exp_lsb = {2'd3, 2'd0, 2'd1, 2'd2};
    vecs[2].exp_msb = {2'd2, 2'd1, 2'd0, 2'd3};
    // 39: 1,2,3,0 / 0,3,2,1
    vecs[3].data = 8'h39; vecs[3].div = 4'd2;
    vecs[3].exp_lsb = {2'd0, 2'd3, 2'd2, 2'd1};
    vecs[3].exp_msb = {2'd1, 2'd2, 2'd3, 2'd0};

    rst = 1'b1;
    a_load = 1'b0; a_data = '0; a_div = '0;
    b_load = 1'b0; b_data = '0; b_div = '0;
    step(); step();
    chk("rst_ren", a_ren, 1'b1);
    chk_a("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_b_ren", b_ren, 1'b1);
    chk("rst_b_sym", b_sym, 2'd0);
    chk("rst_c_sv", c_sv, 1'b0);
    rst = 1'b0;
    step();

    // Table-driven 2-bit symbol runs, LSB-first and MSB-first side by side
    for (int v = 0; v < 4; v++) begin
      b_load = 1'b1; b_data = vecs[v].data; b_div = vecs[v].div;
      step();
      b_load = 1'b0;
      chk("tab_ren_low", b_ren, 1'b0);
      chk("tab_sv_lat", b_sv, 1'b0);
      step();
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c <= int'(vecs[v].div); c++) begin
          chk("tab_b_sv", b_sv, 1'b1);
          chk("tab_b_sym", b_sym, vecs[v].exp_lsb[k]);
          chk("tab_c_sym", c_sym, vecs[v].exp_msb[k]);
          chk("tab_b_fs", b_fs, (k == 0 && c == 0));
          chk("tab_c_fd", c_fd, (k == 3 && c == int'(vecs[v].div)));
          step();
        end
      end
      chk("tab_end_sv", b_sv, 1'b0);
      chk("tab_end_sym", b_sym, 2'd0);
      chk("tab_end_busy", c_busy, 1'b0);
      step();
    end

    // A5 bit-serial, one symbol per cycle
    a_div = 16'd0; a_load = 1'b1; a_data = 8'hA5;
    step();
    a_load = 1'b0;
    chk("t1_ren_low", a_ren, 1'b0);
    chk("t1_sv_lat", a_sv, 1'b0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk_a("t1", 1'b1, t1[i][0], (i == 0), (i == 7));
      chk("t1_ren", a_ren, 1'b1);
      step();
    end
    chk_a("t1_end", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t1_end_busy", a_busy, 1'b0);
    step();

    // 01 at baud_div=3; divider changed mid-word must not matter
    a_div = 16'd3; a_load = 1'b1; a_data = 8'h01;
    step();
    a_load = 1'b0;
    step();
    n_valid = 0; n_fd = 0; fd_idx = -1; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (i == 2) a_div = 16'd0;
      if (a_sv === 1'b1) begin
        if (a_sym !== ((i < 4) ? 1'b1 : 1'b0)) bad++;
        n_valid++;
      end
      if (a_fd === 1'b1) begin
        n_fd++;
        fd_idx = i;
      end
      step();
    end
    chk("t3_valid_cycles", n_valid, 32);
    chk("t3_sym_errs", bad, 0);
    chk("t3_fd_count", n_fd, 1);
    chk("t3_fd_cycle", fd_idx, 31);

    // Back-to-back 0F then F0: zero gap between words
    a_div = 16'd0; a_load = 1'b1; a_data = 8'h0F;
    step();
    a_load = 1'b0;
    chk("t4_ren_low", a_ren, 1'b0);
    w = 0;
    while (a_ren !== 1'b1 && w < 4) begin
      step();
      w++;
    end
    chk("t4_ren_return", a_ren, 1'b1);
    for (int i = 0; i < 16; i++) begin
      chk_a("t4", 1'b1, t4[i][0], (i == 0 || i == 8), (i == 7 || i == 15));
      if (i == 0) begin a_load = 1'b1; a_data = 8'hF0; end
      else a_load = 1'b0;
      step();
    end
    chk("t4_end_sv", a_sv, 1'b0);
    step();

    // Load while ren=0 is ignored; queued word survives
    a_load = 1'b1; a_data = 8'h3C;
    step();
    a_load = 1'b0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk_a("t5", 1'b1, t5[i][0], (i == 0 || i == 8), (i == 7 || i == 15));
      if (i == 0) begin a_load = 1'b1; a_data = 8'h81; end
      else if (i == 1) begin
        chk("t5_ren_blocked", a_ren, 1'b0);
        a_load = 1'b1; a_data = 8'h55;
      end
      else a_load = 1'b0;
      step();
    end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      if (a_sv !== 1'b0) bad++;
      step();
    end
    chk("t5_no_extra_word", bad, 0);

    // Reset on the 4th symbol with a second word queued
    a_load = 1'b1; a_data = 8'h0F;
    step();
    a_load = 1'b0;
    step();
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a_load = 1'b1; a_data = 8'hF0; end
      else a_load = 1'b0;
      if (i == 3) begin
        chk("t6_pre_sv", a_sv, 1'b1);
        rst = 1'b1; a_load = 1'b1; a_data = 8'h55;
      end
      step();
    end
    rst = 1'b0; a_load = 1'b0;
    chk_a("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t6_ren", a_ren, 1'b1);
    chk("t6_busy", a_busy, 1'b0);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (a_sv !== 1'b0 || a_ren !== 1'b1) bad++;
      step();
    end
    chk("t6_silent", bad, 0);

    // Load coinciding with reset while ren=1 is not accepted
    rst = 1'b1; a_load = 1'b1; a_data = 8'hFF;
    step();
    rst = 1'b0; a_load = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      if (a_sv !== 1'b0 || a_ren !== 1'b1) bad++;
      step();
    end
    chk("t7_rst_load_ignored", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
